intersection_model: RTL and testbench

- Behavioural-synthesizable model of the 3-street intersection that sits opposite the traffic light controller.
- Consumes car-arrival pulses and the controller's three light outputs; produces the three traffic sensors that feed back into the controller.
- Maintains per-lane car queues and departures.
- Monitors the light sequence for safety violations (conflicting greens, bad yellow length, missing all-red gap).
- Used in closed-loop benches and on-board demos.

---
 rtl/intersection_model_pkg.sv | 30 +++
 rtl/intersection_model_if.sv | 26 ++
 rtl/intersection_model_lane_queue.sv | 37 +++
 rtl/intersection_model.sv | 168 ++++++++++++++++
 tb/tb_intersection_model.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/intersection_model_pkg.sv
// Shared types for the intersection model: light colors, checker states and error codes.
package light_package;

  typedef enum logic [1:0] {
    COL_RED = 2'd0,
    COL_YEL = 2'd1,
    COL_GRN = 2'd2
  } colors;

  typedef enum logic [2:0] {
    TM_NONE,
    TM_CONFLICT,
    TM_SEQ,
    TM_YELLOW,
    TM_GAP,
    TM_OVF
  } tm_err_t;

  typedef enum logic [1:0] {
    CHK_RED,
    CHK_GRN,
    CHK_YEL
  } chk_st_t;

  // 2'b11 is not a legal color; the checker treats it as red after flagging it.
  function automatic logic color_defined(input colors c);
    return (c == COL_RED) || (c == COL_YEL) || (c == COL_GRN);
  endfunction

endpackage

// File: rtl/intersection_model_if.sv
// Lane-facing bus between the light controller side and the intersection model.
interface intersection_model_if #(
  parameter int QW = 4
);
  logic                ew_str_arrive, ew_left_arrive, ns_arrive;
  light_package::colors ew_str_light, ew_left_light, ns_light;
  logic                ew_str_sensor, ew_left_sensor, ns_sensor;
  logic [QW-1:0]       ew_str_count, ew_left_count, ns_count;
  logic                ew_str_depart, ew_left_depart, ns_depart;

  modport master (
    output ew_str_arrive, ew_left_arrive, ns_arrive,
    output ew_str_light, ew_left_light, ns_light,
    input  ew_str_sensor, ew_left_sensor, ns_sensor,
    input  ew_str_count, ew_left_count, ns_count,
    input  ew_str_depart, ew_left_depart, ns_depart
  );

  modport slave (
    input  ew_str_arrive, ew_left_arrive, ns_arrive,
    input  ew_str_light, ew_left_light, ns_light,
    output ew_str_sensor, ew_left_sensor, ns_sensor,
    output ew_str_count, ew_left_count, ns_count,
    output ew_str_depart, ew_left_depart, ns_depart
  );
endinterface

// File: rtl/intersection_model_lane_queue.sv
// One lane: car queue counter, presence sensor, departure pulse and sticky overflow.
module lane_queue
  import light_package::*;
#(
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive,
  input  colors         light,
  output logic [QW-1:0] count,
  output logic          sensor,
  output logic          depart,
  output logic          ovf,
  output logic          drop
);
  localparam logic [QW-1:0] MAX_CNT = '1;

  logic [QW-1:0] count_q;

  assign depart = (light == COL_GRN) && (count_q != '0);
  assign drop   = arrive && !depart && (count_q == MAX_CNT);
  assign count  = count_q;
  assign sensor = (count_q != '0);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf     <= 1'b0;
    end else begin
      if (arrive && !depart && (count_q != MAX_CNT)) count_q <= count_q + 1'b1;
      else if (depart && !arrive)                    count_q <= count_q - 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/intersection_model.sv
// Intersection model: three lane queues plus a safety monitor on the controller's lights.
module intersection_model
  import light_package::*;
#(
  parameter int QW          = 4,
  parameter int YELLOW_CYC  = 2,
  parameter int MIN_RED_GAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  intersection_model_if.slave  bus,
  output logic [2:0]           ovf,
  output logic                 err_conflict,
  output logic                 err_yellow,
  output logic                 err_seq,
  output logic                 err_gap,
  output tm_err_t              first_err,
  output logic [15:0]          first_err_cyc,
  output logic [15:0]          served
);
  // Lane index 2 = ew_str, 1 = ew_left, 0 = ns, matching the ovf bit order.
  colors      light  [3];
  colors      eff    [3];
  logic [2:0] undef, depart, drop, non_red;

  assign light[2] = bus.ew_str_light;
  assign light[1] = bus.ew_left_light;
  assign light[0] = bus.ns_light;

  lane_queue #(.QW(QW)) u_ew_str (
    .clk(clk), .reset(reset), .arrive(bus.ew_str_arrive), .light(bus.ew_str_light),
    .count(bus.ew_str_count), .sensor(bus.ew_str_sensor), .depart(bus.ew_str_depart),
    .ovf(ovf[2]), .drop(drop[2]));
  lane_queue #(.QW(QW)) u_ew_left (
    .clk(clk), .reset(reset), .arrive(bus.ew_left_arrive), .light(bus.ew_left_light),
    .count(bus.ew_left_count), .sensor(bus.ew_left_sensor), .depart(bus.ew_left_depart),
    .ovf(ovf[1]), .drop(drop[1]));
  lane_queue #(.QW(QW)) u_ns (
    .clk(clk), .reset(reset), .arrive(bus.ns_arrive), .light(bus.ns_light),
    .count(bus.ns_count), .sensor(bus.ns_sensor), .depart(bus.ns_depart),
    .ovf(ovf[0]), .drop(drop[0]));

  assign depart = {bus.ew_str_depart, bus.ew_left_depart, bus.ns_depart};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      undef[i]   = !color_defined(light[i]);
      eff[i]     = undef[i] ? COL_RED : light[i];
      non_red[i] = (eff[i] != COL_RED);
    end
  end

  chk_st_t    st_q  [3];
  chk_st_t    st_d  [3];
  logic [2:0] yel_q [3];
  logic [2:0] yel_d [3];
  logic [2:0] seq_e, yel_e, grn_start, yel_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= CHK_RED;
        yel_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= st_d[i];
        yel_q[i] <= yel_d[i];
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      st_d[i]      = st_q[i];
      yel_d[i]     = yel_q[i];
      seq_e[i]     = undef[i];
      yel_e[i]     = 1'b0;
      grn_start[i] = 1'b0;
      yel_end[i]   = 1'b0;
      unique case (st_q[i])
        CHK_RED: begin
          if (eff[i] == COL_GRN) begin
            st_d[i]      = CHK_GRN;
            grn_start[i] = 1'b1;
          end else if (eff[i] == COL_YEL) begin
            st_d[i]  = CHK_YEL;
            yel_d[i] = '0;
            seq_e[i] = 1'b1;
          end
        end
        CHK_GRN: begin
          if (eff[i] == COL_YEL) begin
            st_d[i]  = CHK_YEL;
            yel_d[i] = '0;
          end else if (eff[i] == COL_RED) begin
            st_d[i]  = CHK_RED;
            seq_e[i] = 1'b1;
          end
        end
        CHK_YEL: begin
          if (eff[i] == COL_YEL) begin
            if (yel_q[i] != 3'd7) yel_d[i] = yel_q[i] + 3'd1;
          end else if (eff[i] == COL_RED) begin
            // The counter holds (run length - 1): it is cleared on the first yellow cycle.
            st_d[i]    = CHK_RED;
            yel_end[i] = 1'b1;
            yel_e[i]   = (int'(yel_q[i]) + 1 != YELLOW_CYC);
          end else begin
            st_d[i]  = CHK_GRN;
            seq_e[i] = 1'b1;
            yel_e[i] = 1'b1;
          end
        end
        default: st_d[i] = CHK_RED;
      endcase
    end
  end

  // A yellow ending this cycle restarts the gap count before this cycle's all-red is counted.
  logic [3:0] gap_q, gap_base, gap_d;
  logic       all_red, gap_e, conflict_e;

  assign all_red    = (non_red == 3'b000);
  assign gap_base   = (|yel_end) ? 4'd0 : gap_q;
  assign gap_d      = (all_red && gap_base != 4'hF) ? gap_base + 4'd1 : gap_base;
  assign gap_e      = (|grn_start) && (int'(gap_base) < MIN_RED_GAP);
  assign conflict_e = ($countones(non_red) > 1);

  tm_err_t     err_code;
  logic [15:0] cyc_q;

  always_comb begin
    err_code = TM_NONE;
    if      (conflict_e) err_code = TM_CONFLICT;
    else if (|seq_e)     err_code = TM_SEQ;
    else if (|yel_e)     err_code = TM_YELLOW;
    else if (gap_e)      err_code = TM_GAP;
    else if (|drop)      err_code = TM_OVF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_q         <= 4'(MIN_RED_GAP);
      cyc_q         <= '0;
      served        <= '0;
      err_conflict  <= 1'b0;
      err_yellow    <= 1'b0;
      err_seq       <= 1'b0;
      err_gap       <= 1'b0;
      first_err     <= TM_NONE;
      first_err_cyc <= '0;
    end else begin
      gap_q  <= gap_d;
      cyc_q  <= cyc_q + 16'd1;
      served <= served + 16'($countones(depart));
      if (conflict_e) err_conflict <= 1'b1;
      if (|yel_e)     err_yellow   <= 1'b1;
      if (|seq_e)     err_seq      <= 1'b1;
      if (gap_e)      err_gap      <= 1'b1;
      if (first_err == TM_NONE && err_code != TM_NONE) begin
        first_err     <= err_code;
        first_err_cyc <= cyc_q;
      end
    end
  end
endmodule

// File: tb/tb_intersection_model.sv
// Directed bench for intersection_model: queue/depart vector table plus monitor corner cases.
module tb_intersection_model;
  import light_package::*;

  localparam int QW = 4;
  localparam colors R = COL_RED;
  localparam colors Y = COL_YEL;
  localparam colors G = COL_GRN;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  ovf;
  logic        err_conflict, err_yellow, err_seq, err_gap;
  tm_err_t     first_err;
  logic [15:0] first_err_cyc, served;
  logic [15:0] tb_cyc;

  always #5 clk = ~clk;

  intersection_model_if #(.QW(QW)) bus ();

  intersection_model #(.QW(QW), .YELLOW_CYC(2), .MIN_RED_GAP(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .ovf(ovf),
    .err_conflict(err_conflict), .err_yellow(err_yellow), .err_seq(err_seq),
    .err_gap(err_gap), .first_err(first_err), .first_err_cyc(first_err_cyc),
    .served(served));

  // Cycle index as the design should see it: 0 in the first cycle after reset release.
  always @(posedge clk or negedge reset)
    if (!reset) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 16'd1;

  typedef struct {
    logic [2:0] arr;
    colors      l_es, l_el, l_ns;
    logic [2:0] dep;
    logic [3:0] c_es, c_el, c_ns;
    logic [15:0] srv;
  } vec_t;

  vec_t vecs [23];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic [2:0] arr, input colors es, el, ns,
                              input logic [2:0] dep, input logic [3:0] ces, cel, cns,
                              input logic [15:0] srv);
    vec_t v;
    v.arr = arr; v.l_es = es; v.l_el = el; v.l_ns = ns;
    v.dep = dep; v.c_es = ces; v.c_el = cel; v.c_ns = cns; v.srv = srv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input colors es, input colors el, input colors ns);
    bus.ew_str_arrive  = a[2];
    bus.ew_left_arrive = a[1];
    bus.ns_arrive      = a[0];
    bus.ew_str_light   = es;
    bus.ew_left_light  = el;
    bus.ns_light       = ns;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(3'b000, R, R, R);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_errs(input string tag, input logic [3:0] exp_flags, input tm_err_t exp_first);
    check({tag, " flags"}, {err_conflict, err_seq, err_yellow, err_gap}, exp_flags);
    check({tag, " first_err"}, first_err, exp_first);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ovf_cyc;

    //                arr     es el ns  dep     es    el    ns    served
    vecs[0]  = mk(3'b100, R, R, R, 3'b000, 4'd1, 4'd0, 4'd0, 16'd0);
    vecs[1]  = mk(3'b100, R, R, R, 3'b000, 4'd2, 4'd0, 4'd0, 16'd0);
    vecs[2]  = mk(3'b100, R, R, R, 3'b000, 4'd3, 4'd0, 4'd0, 16'd0);
    vecs[3]  = mk(3'b000, G, R, R, 3'b100, 4'd2, 4'd0, 4'd0, 16'd1);
    vecs[4]  = mk(3'b000, G, R, R, 3'b100, 4'd1, 4'd0, 4'd0, 16'd2);
    vecs[5]  = mk(3'b000, G, R, R, 3'b100, 4'd0, 4'd0, 4'd0, 16'd3);
    vecs[6]  = mk(3'b000, G, R, R, 3'b000, 4'd0, 4'd0, 4'd0, 16'd3);
    vecs[7]  = mk(3'b000, G, R, R, 3'b000, 4'd0, 4'd0, 4'd0, 16'd3);
    vecs[8]  = mk(3'b000, Y, R, R, 3'b000, 4'd0, 4'd0, 4'd0, 16'd3);
    vecs[9]  = mk(3'b000, Y, R, R, 3'b000, 4'd0, 4'd0, 4'd0, 16'd3);
    vecs[10] = mk(3'b000, R, R, R, 3'b000, 4'd0, 4'd0, 4'd0, 16'd3);
    vecs[11] = mk(3'b011, R, R, R, 3'b000, 4'd0, 4'd1, 4'd1, 16'd3);
    vecs[12] = mk(3'b010, R, R, R, 3'b000, 4'd0, 4'd2, 4'd1, 16'd3);
    vecs[13] = mk(3'b010, R, G, R, 3'b010, 4'd0, 4'd2, 4'd1, 16'd4);
    vecs[14] = mk(3'b000, R, G, R, 3'b010, 4'd0, 4'd1, 4'd1, 16'd5);
    vecs[15] = mk(3'b000, R, Y, R, 3'b000, 4'd0, 4'd1, 4'd1, 16'd5);
    vecs[16] = mk(3'b000, R, Y, R, 3'b000, 4'd0, 4'd1, 4'd1, 16'd5);
    vecs[17] = mk(3'b000, R, R, R, 3'b000, 4'd0, 4'd1, 4'd1, 16'd5);
    vecs[18] = mk(3'b001, R, R, G, 3'b001, 4'd0, 4'd1, 4'd1, 16'd6);
    vecs[19] = mk(3'b000, R, R, G, 3'b001, 4'd0, 4'd1, 4'd0, 16'd7);
    vecs[20] = mk(3'b000, R, R, Y, 3'b000, 4'd0, 4'd1, 4'd0, 16'd7);
    vecs[21] = mk(3'b000, R, R, Y, 3'b000, 4'd0, 4'd1, 4'd0, 16'd7);
    vecs[22] = mk(3'b000, R, R, R, 3'b000, 4'd0, 4'd1, 4'd0, 16'd7);

    // Reset state, observed while reset is still held.
    drive(3'b000, R, R, R);
    reset = 1'b0;
    tick();
    tick();
    check("rst counts", {bus.ew_str_count, bus.ew_left_count, bus.ns_count}, 12'h000);
    check("rst sensors", {bus.ew_str_sensor, bus.ew_left_sensor, bus.ns_sensor}, 3'b000);
    check("rst served", served, 16'd0);
    check("rst ovf", ovf, 3'b000);
    check("rst first_err_cyc", first_err_cyc, 16'd0);
    check_errs("rst", 4'b0000, TM_NONE);
    reset = 1'b1;

    // Queue / departure table: depart is combinational, counts are registered.
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].arr, vecs[i].l_es, vecs[i].l_el, vecs[i].l_ns);
      #1;
      check($sformatf("v%0d depart", i),
            {bus.ew_str_depart, bus.ew_left_depart, bus.ns_depart}, vecs[i].dep);
      @(posedge clk);
      #1;
      check($sformatf("v%0d counts", i), {bus.ew_str_count, bus.ew_left_count, bus.ns_count},
            {vecs[i].c_es, vecs[i].c_el, vecs[i].c_ns});
      check($sformatf("v%0d sensors", i), {bus.ew_str_sensor, bus.ew_left_sensor, bus.ns_sensor},
            {vecs[i].c_es != 4'd0, vecs[i].c_el != 4'd0, vecs[i].c_ns != 4'd0});
      check($sformatf("v%0d served", i), served, vecs[i].srv);
    end
    check_errs("table", 4'b0000, TM_NONE);

    // Overflow: 16 arrivals into an empty ew_str lane saturate at 15 and drop the last car.
    ovf_cyc = '0;
    for (int k = 0; k < 16; k++) begin
      drive(3'b100, R, R, R);
      if (k == 15) ovf_cyc = tb_cyc;
      tick();
      if (k == 14) check("ovf before drop", ovf, 3'b000);
    end
    drive(3'b000, R, R, R);
    check("ovf count", bus.ew_str_count, 4'd15);
    check("ovf sensor", bus.ew_str_sensor, 1'b1);
    check("ovf bits", ovf, 3'b100);
    check("ovf first_err", first_err, TM_OVF);
    check("ovf first_err_cyc", first_err_cyc, ovf_cyc);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    #3;
    reset = 1'b0;
    #1;
    check("async rst counts", {bus.ew_str_count, bus.ew_left_count, bus.ns_count}, 12'h000);
    check("async rst ovf", ovf, 3'b000);
    check("async rst served", served, 16'd0);
    check("async rst first_err", first_err, TM_NONE);
    tick();
    reset = 1'b1;

    // Conflict at cycle 40, then a later sequence error must not change the capture.
    for (int g = 0; g < 100 && tb_cyc != 16'd40; g++) tick();
    drive(3'b000, G, R, G);
    tick();
    check("conflict flag", err_conflict, 1'b1);
    check("conflict first_err", first_err, TM_CONFLICT);
    check("conflict first_err_cyc", first_err_cyc, 16'd40);
    drive(3'b000, R, R, R);
    tick();
    check("later seq flag", err_seq, 1'b1);
    check("later first_err", first_err, TM_CONFLICT);
    check("later first_err_cyc", first_err_cyc, 16'd40);

    // Yellow held for 3 cycles instead of 2.
    do_reset();
    drive(3'b000, R, R, G); tick();
    for (int k = 0; k < 3; k++) begin drive(3'b000, R, R, Y); tick(); end
    drive(3'b000, R, R, R); tick();
    check_errs("long yellow", 4'b0010, TM_YELLOW);

    // Green directly to red.
    do_reset();
    drive(3'b000, R, R, G); tick();
    drive(3'b000, R, R, R); tick();
    check_errs("green to red", 4'b0100, TM_SEQ);

    // Undefined color: sequence error, and it counts as red for conflict purposes.
    do_reset();
    drive(3'b000, G, R, colors'(2'b11)); tick();
    check_errs("undef color", 4'b0100, TM_SEQ);

    // Green right after a yellow ends, with no all-red cycle in between.
    do_reset();
    drive(3'b000, R, G, R); tick();
    drive(3'b000, R, Y, R); tick();
    drive(3'b000, R, Y, R); tick();
    drive(3'b000, R, R, G); tick();
    check_errs("no gap", 4'b0001, TM_GAP);

    // Same sequence with one all-red cycle inserted is legal.
    do_reset();
    drive(3'b000, R, G, R); tick();
    drive(3'b000, R, Y, R); tick();
    drive(3'b000, R, Y, R); tick();
    drive(3'b000, R, R, R); tick();
    drive(3'b000, R, R, G); tick();
    check_errs("one gap", 4'b0000, TM_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
